// File: rtl/alu_issue_sequencer.sv
//==============================================================================
// Module      : alu_issue_sequencer
// Description : Multi-cycle issue sequencer for the 8-bit ALU. Accepts one
//               32-bit instruction per valid/ready handshake, reads operands
//               from the register file, drives the ALU for a configurable
//               number of cycles, then issues a writeback or branch strobe.
//               Optional build macro ILLEGAL_TRAP_EN: undefined opcodes raise
//               a sticky ILLEGAL flag and park the sequencer in HALT until
//               reset. Without it, undefined opcodes retire as a NOP.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_issue_sequencer #(
    parameter int ALU_CYCLES  = 1,
    parameter int MULT_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic [2:0]  OUT1ADDRESS,
    output logic [2:0]  OUT2ADDRESS,
    input  logic [7:0]  REGOUT1,
    input  logic [7:0]  REGOUT2,
    output logic [7:0]  ALU_DATA1,
    output logic [7:0]  ALU_DATA2,
    output logic [2:0]  ALU_SELECT,
    input  logic [7:0]  ALU_RESULT,
    input  logic        ALU_ZERO,
    output logic        WRITEENABLE,
    output logic [2:0]  INADDRESS,
    output logic [7:0]  IN,
    output logic        BRANCH_TAKEN,
    output logic [7:0]  BRANCH_OFFSET,
    output logic        ILLEGAL
);

    // Counter must hold the larger of the two wait lengths
    localparam int c_MAX_CYC = (ALU_CYCLES > MULT_CYCLES) ? ALU_CYCLES : MULT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_ALU_LOAD  = c_CNT_W'(ALU_CYCLES);
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(1);

    localparam logic [7:0] c_OP_LOADI = 8'd0;
    localparam logic [7:0] c_OP_MOV   = 8'd1;
    localparam logic [7:0] c_OP_ADD   = 8'd2;
    localparam logic [7:0] c_OP_SUB   = 8'd3;
    localparam logic [7:0] c_OP_AND   = 8'd4;
    localparam logic [7:0] c_OP_OR    = 8'd5;
    localparam logic [7:0] c_OP_J     = 8'd6;
    localparam logic [7:0] c_OP_BEQ   = 8'd7;
    localparam logic [7:0] c_OP_BNE   = 8'd8;
    localparam logic [7:0] c_OP_MULT  = 8'd9;
    localparam logic [7:0] c_OP_SLL   = 8'd10;
    localparam logic [7:0] c_OP_SRL   = 8'd11;
    localparam logic [7:0] c_OP_SRA   = 8'd12;
    localparam logic [7:0] c_OP_ROR   = 8'd13;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t             r_state;
    logic [7:0]         r_opcode;
    logic [7:0]         r_offset;
    logic [7:0]         r_imm;
    logic [c_CNT_W-1:0] r_cnt;

    logic [2:0] w_sel;
    logic [7:0] w_d1;
    logic [7:0] w_d2;
    logic       w_write;
    logic       w_jump;
    logic       w_beq;
    logic       w_bne;
    logic       w_mult;
    logic       w_legal;
    logic       w_take;
    logic [7:0] w_neg_r2;
    logic [7:0] w_neg_imm;

    // Register address fields only use the low three bits of each byte
    logic w_unused;
    assign w_unused = &{1'b0, INSTR[15:11], INSTR[7:3]};

    assign w_neg_r2  = ~REGOUT2 + 8'd1;
    assign w_neg_imm = ~r_imm + 8'd1;

    // Branch outcome resolves on the captured ALU zero flag
    assign w_take = (w_beq & ALU_ZERO) | (w_bne & ~ALU_ZERO);

    // Opcode decode; operand values only matter at the end of READ, flags are stable all instruction
    always_comb begin
        w_sel   = 3'b000;
        w_d1    = 8'h00;
        w_d2    = 8'h00;
        w_write = 1'b0;
        w_jump  = 1'b0;
        w_beq   = 1'b0;
        w_bne   = 1'b0;
        w_mult  = 1'b0;
        w_legal = 1'b1;
        case (r_opcode)
            c_OP_LOADI: begin w_d2 = r_imm;                                   w_write = 1'b1; end
            c_OP_MOV:   begin w_d2 = REGOUT2;                                 w_write = 1'b1; end
            c_OP_ADD:   begin w_sel = 3'b001; w_d1 = REGOUT1; w_d2 = REGOUT2;   w_write = 1'b1; end
            c_OP_SUB:   begin w_sel = 3'b001; w_d1 = REGOUT1; w_d2 = w_neg_r2;  w_write = 1'b1; end
            c_OP_AND:   begin w_sel = 3'b010; w_d1 = REGOUT1; w_d2 = REGOUT2;   w_write = 1'b1; end
            c_OP_OR:    begin w_sel = 3'b011; w_d1 = REGOUT1; w_d2 = REGOUT2;   w_write = 1'b1; end
            c_OP_J:     begin w_jump = 1'b1; end
            c_OP_BEQ:   begin w_sel = 3'b001; w_d1 = REGOUT1; w_d2 = w_neg_r2;  w_beq = 1'b1; end
            c_OP_BNE:   begin w_sel = 3'b001; w_d1 = REGOUT1; w_d2 = w_neg_r2;  w_bne = 1'b1; end
            c_OP_MULT:  begin w_sel = 3'b111; w_d1 = REGOUT1; w_d2 = REGOUT2;   w_write = 1'b1; w_mult = 1'b1; end
            c_OP_SLL:   begin w_sel = 3'b100; w_d1 = REGOUT1; w_d2 = r_imm;     w_write = 1'b1; end
            c_OP_SRL:   begin w_sel = 3'b100; w_d1 = REGOUT1; w_d2 = w_neg_imm; w_write = 1'b1; end
            c_OP_SRA:   begin w_sel = 3'b101; w_d1 = REGOUT1; w_d2 = r_imm;     w_write = 1'b1; end
            c_OP_ROR:   begin w_sel = 3'b110; w_d1 = REGOUT1; w_d2 = r_imm;     w_write = 1'b1; end
            default:    begin w_legal = 1'b0; end
        endcase
    end

`ifndef ILLEGAL_TRAP_EN
    assign ILLEGAL = 1'b0;
`endif

    // Sequencer FSM with all outputs registered
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= S_IDLE;
            r_opcode      <= 8'h00;
            r_offset      <= 8'h00;
            r_imm         <= 8'h00;
            r_cnt         <= '0;
            INSTR_READY   <= 1'b0;
            OUT1ADDRESS   <= 3'd0;
            OUT2ADDRESS   <= 3'd0;
            ALU_DATA1     <= 8'h00;
            ALU_DATA2     <= 8'h00;
            ALU_SELECT    <= 3'd0;
            WRITEENABLE   <= 1'b0;
            INADDRESS     <= 3'd0;
            IN            <= 8'h00;
            BRANCH_TAKEN  <= 1'b0;
            BRANCH_OFFSET <= 8'h00;
`ifdef ILLEGAL_TRAP_EN
            ILLEGAL       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (INSTR_READY && INSTR_VALID) begin
                        r_opcode    <= INSTR[31:24];
                        r_offset    <= INSTR[23:16];
                        r_imm       <= INSTR[7:0];
                        OUT1ADDRESS <= INSTR[10:8];
                        OUT2ADDRESS <= INSTR[2:0];
                        INADDRESS   <= INSTR[18:16];
                        INSTR_READY <= 1'b0;
                        r_state     <= S_READ;
                    end else begin
                        INSTR_READY <= 1'b1;
                    end
                end
                S_READ: begin
                    OUT1ADDRESS <= 3'd0;
                    OUT2ADDRESS <= 3'd0;
                    if (w_jump) begin
                        BRANCH_TAKEN  <= 1'b1;
                        BRANCH_OFFSET <= r_offset;
                        r_state       <= S_WB;
                    end else if (!w_legal) begin
`ifdef ILLEGAL_TRAP_EN
                        ILLEGAL <= 1'b1;
                        r_state <= S_HALT;
`else
                        r_state <= S_WB;
`endif
                    end else begin
                        ALU_DATA1  <= w_d1;
                        ALU_DATA2  <= w_d2;
                        ALU_SELECT <= w_sel;
                        r_cnt      <= w_mult ? c_MULT_LOAD : c_ALU_LOAD;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == c_CNT_LAST) begin
                        IN            <= ALU_RESULT;
                        WRITEENABLE   <= w_write;
                        BRANCH_TAKEN  <= w_take;
                        BRANCH_OFFSET <= w_take ? r_offset : 8'h00;
                        ALU_DATA1     <= 8'h00;
                        ALU_DATA2     <= 8'h00;
                        ALU_SELECT    <= 3'd0;
                        r_state       <= S_WB;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_LAST;
                    end
                end
                S_WB: begin
                    WRITEENABLE   <= 1'b0;
                    BRANCH_TAKEN  <= 1'b0;
                    BRANCH_OFFSET <= 8'h00;
                    INADDRESS     <= 3'd0;
                    INSTR_READY   <= 1'b1;
                    r_state       <= S_IDLE;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_sequencer.sv
//==============================================================================
// Module      : tb_alu_issue_sequencer
// Description : Scoreboard bench for alu_issue_sequencer with a behavioural
//               register file and ALU. Strobe expectations are queued at
//               issue and popped by an independent monitor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_issue_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] INSTR = 32'h0;
    logic        INSTR_VALID = 1'b0;
    logic        INSTR_READY;
    logic [2:0]  OUT1ADDRESS, OUT2ADDRESS;
    logic [7:0]  REGOUT1, REGOUT2;
    logic [7:0]  ALU_DATA1, ALU_DATA2;
    logic [2:0]  ALU_SELECT;
    logic [7:0]  ALU_RESULT;
    logic        ALU_ZERO;
    logic        WRITEENABLE;
    logic [2:0]  INADDRESS;
    logic [7:0]  IN;
    logic        BRANCH_TAKEN;
    logic [7:0]  BRANCH_OFFSET;
    logic        ILLEGAL;

    alu_issue_sequencer #(.ALU_CYCLES(1), .MULT_CYCLES(3)) dut (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .REGOUT1(REGOUT1), .REGOUT2(REGOUT2), .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2),
        .ALU_SELECT(ALU_SELECT), .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO),
        .WRITEENABLE(WRITEENABLE), .INADDRESS(INADDRESS), .IN(IN),
        .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_OFFSET(BRANCH_OFFSET), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // Rising-edge count; at a falling edge it equals the number of edges so far
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Static register file contents
    logic [7:0] rf [8];
    assign REGOUT1 = rf[OUT1ADDRESS];
    assign REGOUT2 = rf[OUT2ADDRESS];

    // Behavioural ALU
    logic [7:0]  alu_r;
    logic [15:0] alu_t;
    always_comb begin
        alu_r = 8'h00;
        alu_t = 16'h0000;
        case (ALU_SELECT)
            3'b000: alu_r = ALU_DATA2;
            3'b001: alu_r = ALU_DATA1 + ALU_DATA2;
            3'b010: alu_r = ALU_DATA1 & ALU_DATA2;
            3'b011: alu_r = ALU_DATA1 | ALU_DATA2;
            3'b100: alu_r = ALU_DATA2[7] ? (ALU_DATA1 >> (8'd0 - ALU_DATA2)) : (ALU_DATA1 << ALU_DATA2);
            3'b101: alu_r = $signed(ALU_DATA1) >>> ALU_DATA2[2:0];
            3'b110: begin alu_t = {ALU_DATA1, ALU_DATA1} >> ALU_DATA2[2:0]; alu_r = alu_t[7:0]; end
            default: begin alu_t = ALU_DATA1 * ALU_DATA2; alu_r = alu_t[7:0]; end
        endcase
    end
    assign ALU_RESULT = alu_r;
    assign ALU_ZERO   = (alu_r == 8'h00);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         br;
        logic [2:0] addr;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge CLK) begin
        if (RESET && (WRITEENABLE || BRANCH_TAKEN)) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe: actual we=%0b br=%0b expected no strobe", WRITEENABLE, BRANCH_TAKEN);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_cycle", cyc, mon_e.cyc);
                chk("branch_taken", {31'd0, BRANCH_TAKEN}, {31'd0, mon_e.br});
                chk("writeenable", {31'd0, WRITEENABLE}, {31'd0, !mon_e.br});
                if (mon_e.br) begin
                    chk("branch_offset", {24'd0, BRANCH_OFFSET}, {24'd0, mon_e.val});
                end else begin
                    chk("inaddress", {29'd0, INADDRESS}, {29'd0, mon_e.addr});
                    chk("in_data", {24'd0, IN}, {24'd0, mon_e.val});
                end
            end
        end else if (RESET && BRANCH_OFFSET != 8'h00) begin
            checks++; errors++;
            $display("FAIL offset_without_branch: actual=%0h expected=0", BRANCH_OFFSET);
        end
    end

    // Issue one instruction; lat is the 1-based cycle after the accept edge in which the strobe shows
    task automatic send(input logic [31:0] ins, input bit push, input bit br, input logic [2:0] addr,
                        input logic [7:0] val, input int lat, input bit keep, output int acc);
        int n;
        exp_t e;
        @(negedge CLK);
        INSTR = ins;
        INSTR_VALID = 1'b1;
        n = 0;
        while (!INSTR_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!INSTR_READY) begin
            checks++; errors++;
            $display("FAIL accept_timeout: actual ready=0 after %0d cycles, expected 1", n);
        end
        acc = cyc + 1;
        if (push) begin
            e.br = br; e.addr = addr; e.val = val; e.cyc = acc + lat - 1;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        if (!keep) INSTR_VALID = 1'b0;
    endtask

    int acc, acc2, n;

    initial begin
        rf[0] = 8'h05; rf[1] = 8'h10; rf[2] = 8'h03; rf[3] = 8'h04;
        rf[4] = 8'h55; rf[5] = 8'h81; rf[6] = 8'h55; rf[7] = 8'h56;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("reset_ready", {31'd0, INSTR_READY}, 32'd0);
        chk("reset_strobes", {30'd0, WRITEENABLE, BRANCH_TAKEN}, 32'd0);
        chk("reset_alu", {5'd0, ALU_SELECT, ALU_DATA1, ALU_DATA2, 8'd0}, 32'd0);
        RESET = 1'b1;
        #1 chk("ready_before_first_edge", {31'd0, INSTR_READY}, 32'd0);
        @(negedge CLK);
        chk("ready_after_first_edge", {31'd0, INSTR_READY}, 32'd1);

        // loadi r3, 0x2A
        send({8'h00, 8'h03, 8'h00, 8'h2A}, 1, 0, 3'd3, 8'h2A, 3, 0, acc);
        @(negedge CLK);
        chk("read_ready_low", {31'd0, INSTR_READY}, 32'd0);
        @(negedge CLK);
        chk("loadi_select", {29'd0, ALU_SELECT}, 32'd0);
        chk("loadi_data2", {24'd0, ALU_DATA2}, 32'h2A);

        // sub r5 = r1 - r2 = 0x10 - 0x03
        send({8'h03, 8'h05, 8'h01, 8'h02}, 1, 0, 3'd5, 8'h0D, 3, 0, acc);
        @(negedge CLK);
        chk("sub_rd_addr1", {29'd0, OUT1ADDRESS}, 32'd1);
        chk("sub_rd_addr2", {29'd0, OUT2ADDRESS}, 32'd2);
        @(negedge CLK);
        chk("sub_select", {29'd0, ALU_SELECT}, 32'd1);
        chk("sub_data1", {24'd0, ALU_DATA1}, 32'h10);
        chk("sub_data2", {24'd0, ALU_DATA2}, 32'hFD);

        // beq taken / not taken, bne inverse
        send({8'h07, 8'hFE, 8'h04, 8'h06}, 1, 1, 3'd0, 8'hFE, 3, 0, acc);
        send({8'h07, 8'hFE, 8'h04, 8'h07}, 0, 0, 3'd0, 8'h00, 3, 0, acc);
        send({8'h08, 8'hFE, 8'h04, 8'h06}, 0, 0, 3'd0, 8'h00, 3, 0, acc);
        send({8'h08, 8'h10, 8'h04, 8'h07}, 1, 1, 3'd0, 8'h10, 3, 0, acc);

        // Remaining write-back ops
        send({8'h02, 8'h01, 8'h01, 8'h02}, 1, 0, 3'd1, 8'h13, 3, 0, acc);
        send({8'h04, 8'h02, 8'h04, 8'h07}, 1, 0, 3'd2, 8'h54, 3, 0, acc);
        send({8'h05, 8'h02, 8'h04, 8'h07}, 1, 0, 3'd2, 8'h57, 3, 0, acc);
        send({8'h01, 8'h07, 8'h00, 8'h06}, 1, 0, 3'd7, 8'h55, 3, 0, acc);
        send({8'h06, 8'h20, 8'h00, 8'h00}, 1, 1, 3'd0, 8'h20, 2, 0, acc);
        send({8'h0A, 8'h01, 8'h05, 8'h03}, 1, 0, 3'd1, 8'h08, 3, 0, acc);
        send({8'h0B, 8'h01, 8'h05, 8'h03}, 1, 0, 3'd1, 8'h10, 3, 0, acc);
        @(negedge CLK);
        @(negedge CLK);
        chk("srl_data2", {24'd0, ALU_DATA2}, 32'hFD);
        send({8'h0C, 8'h02, 8'h05, 8'h02}, 1, 0, 3'd2, 8'hE0, 3, 0, acc);
        send({8'h0D, 8'h03, 8'h05, 8'h04}, 1, 0, 3'd3, 8'h18, 3, 0, acc);

        // mult with INSTR_VALID held high across the whole instruction
        send({8'h09, 8'h06, 8'h00, 8'h03}, 1, 0, 3'd6, 8'h14, 5, 1, acc);
        @(negedge CLK);
        chk("mult_read_ready", {31'd0, INSTR_READY}, 32'd0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge CLK);
            chk("mult_select_held", {29'd0, ALU_SELECT}, 32'd7);
        end
        @(negedge CLK);
        chk("mult_wb_ready", {31'd0, INSTR_READY}, 32'd0);
        send({8'h09, 8'h06, 8'h00, 8'h03}, 1, 0, 3'd6, 8'h14, 5, 0, acc2);
        chk("mult_reaccept_edge", acc2, acc + 6);

        // Undefined opcode
`ifdef ILLEGAL_TRAP_EN
        send({8'hF0, 8'h01, 8'h01, 8'h02}, 0, 0, 3'd0, 8'h00, 2, 0, acc);
        repeat (2) @(negedge CLK);
        chk("illegal_set", {31'd0, ILLEGAL}, 32'd1);
        repeat (5) @(negedge CLK);
        chk("halt_ready", {31'd0, INSTR_READY}, 32'd0);
        chk("illegal_sticky", {31'd0, ILLEGAL}, 32'd1);
        RESET = 1'b0;
        #1 chk("illegal_cleared", {31'd0, ILLEGAL}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
`else
        send({8'hF0, 8'h01, 8'h01, 8'h02}, 0, 0, 3'd0, 8'h00, 2, 0, acc);
        @(negedge CLK);
        chk("nop_read_ready", {31'd0, INSTR_READY}, 32'd0);
        @(negedge CLK);
        chk("nop_wb_ready", {31'd0, INSTR_READY}, 32'd0);
        chk("nop_illegal", {31'd0, ILLEGAL}, 32'd0);
        @(negedge CLK);
        chk("nop_idle_ready", {31'd0, INSTR_READY}, 32'd1);
`endif
        send({8'h00, 8'h04, 8'h00, 8'h77}, 1, 0, 3'd4, 8'h77, 3, 0, acc);

        // Reset in the middle of EXEC for add: no write-back may follow
        send({8'h02, 8'h01, 8'h01, 8'h02}, 0, 0, 3'd0, 8'h00, 3, 0, acc);
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_exec_select", {29'd0, ALU_SELECT}, 32'd1);
        RESET = 1'b0;
        #1;
        chk("abort_out_a", {INSTR_READY, OUT1ADDRESS, OUT2ADDRESS, ALU_SELECT, ALU_DATA1, ALU_DATA2, 6'd0}, 32'd0);
        chk("abort_out_b", {WRITEENABLE, INADDRESS, IN, BRANCH_TAKEN, BRANCH_OFFSET, ILLEGAL, 10'd0}, 32'd0);
        repeat (3) @(negedge CLK);
        chk("abort_ready_in_reset", {31'd0, INSTR_READY}, 32'd0);
        RESET = 1'b1;
        #1 chk("abort_ready_before_edge", {31'd0, INSTR_READY}, 32'd0);
        @(negedge CLK);
        chk("abort_ready_after_edge", {31'd0, INSTR_READY}, 32'd1);
        repeat (3) @(negedge CLK);
        send({8'h00, 8'h06, 8'h00, 8'h3C}, 1, 0, 3'd6, 8'h3C, 3, 0, acc);

        // Drain the scoreboard
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("scoreboard_empty", sb.size(), 32'd0);
        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Multi-cycle initiator for the 8-bit ALU.
- Accepts one 32-bit instruction per valid/ready handshake, reads operands from the register file, decodes the opcode into ALU SELECT and operand values, waits for the ALU result, then issues writeback or a branch decision.
- Sits between instruction fetch and the register file/ALU pair, replacing the combinational control path.

Parameters:
- ALU_CYCLES, 1, EXEC wait cycles for non-multiply ops (>=1).
- MULT_CYCLES, 3, EXEC wait cycles for SELECT 111 (>=1).

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-low reset
- INSTR  input  32  [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/imm
- INSTR_VALID  input  1  instruction offered
- INSTR_READY  output  1  sequencer can accept
- OUT1ADDRESS  output  3  register file read address 1 (INSTR[10:8])
- OUT2ADDRESS  output  3  register file read address 2 (INSTR[2:0])
- REGOUT1  input  8  register read data 1
- REGOUT2  input  8  register read data 2
- ALU_DATA1  output  8  ALU operand 1
- ALU_DATA2  output  8  ALU operand 2
- ALU_SELECT  output  3  ALU op select
- ALU_RESULT  input  8  ALU result
- ALU_ZERO  input  1  ALU zero flag (valid for SELECT 001 only)
- WRITEENABLE  output  1  one-cycle writeback strobe
- INADDRESS  output  3  write address (INSTR[18:16])
- IN  output  8  write data
- BRANCH_TAKEN  output  1  one-cycle branch strobe
- BRANCH_OFFSET  output  8  signed word offset (INSTR[23:16])
- ILLEGAL  output  1  undefined-opcode indicator

Behaviour:
- Reset (RESET=0, asynchronous):
  - state IDLE.
  - INSTR_READY=0 while RESET=0, then 1 from the first clock edge after release.
  - All other outputs are 0.
  - Reset mid-operation abandons the instruction with no writeback or branch.
- States IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: INSTR_READY=1. On INSTR_VALID&INSTR_READY, latch INSTR and go to READ.
  - READ: drive OUT1ADDRESS/OUT2ADDRESS (one cycle). Capture REGOUT1/REGOUT2 at the end of the cycle.
  - EXEC: drive ALU_DATA1/ALU_DATA2/ALU_SELECT stably. The down-counter is loaded with ALU_CYCLES, or MULT_CYCLES for mult. Capture ALU_RESULT/ALU_ZERO on the cycle the counter reaches 1.
  - WB: one cycle. Pulse WRITEENABLE or BRANCH_TAKEN per opcode, then return to IDLE.
- Latency: accept edge to WB strobe = 2 + N cycles, with N = ALU_CYCLES or MULT_CYCLES. j skips EXEC (2 cycles).
- INSTR_READY=0 outside IDLE. INSTR_VALID is ignored there and the instruction is not latched.
- Decode (opcode -> SELECT, DATA1, DATA2, result):
  - 0 loadi -> 000, DATA2=imm, write
  - 1 mov -> 000, DATA2=REGOUT2, write
  - 2 add -> 001, REGOUT1, REGOUT2, write
  - 3 sub -> 001, REGOUT1, ~REGOUT2+1 (mod 256), write
  - 4 and -> 010, REGOUT1, REGOUT2, write
  - 5 or -> 011, REGOUT1, REGOUT2, write
  - 6 j -> no ALU, BRANCH_TAKEN
  - 7 beq -> 001 with negated REGOUT2, BRANCH_TAKEN iff ALU_ZERO=1, no write
  - 8 bne -> as beq, taken iff ALU_ZERO=0
  - 9 mult -> 111, REGOUT1, REGOUT2, write low 8 bits
  - 10 sll -> 100, REGOUT1, DATA2=imm
  - 11 srl -> 100, REGOUT1, DATA2=~imm+1 (negative amount = right shift)
  - 12 sra -> 101, REGOUT1, imm
  - 13 ror -> 110, REGOUT1, imm
  - 10-13 all write back.
- IN = captured ALU_RESULT. INADDRESS is held from the latch until WB ends.
- BRANCH_OFFSET is driven with BRANCH_TAKEN and is 0 otherwise.
- Opcodes 14-255 are undefined.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode sets ILLEGAL, which is sticky.
  - The sequencer parks in a HALT state with INSTR_READY=0 until reset.
- Undefined:
  - An undefined opcode retires as a NOP through READ -> WB with no strobes.
  - ILLEGAL is tied 0.

Test Plan:
- Reset: RESET=0 mid-EXEC of add -> WRITEENABLE never pulses, INSTR_READY=0 during reset and 1 from the first clock edge after release, all outputs 0.
- loadi r3,0x2A, ALU_CYCLES=1:
  - ALU_SELECT=000, ALU_DATA2=0x2A.
  - WRITEENABLE pulses exactly 3 cycles after the accept edge, INADDRESS=3, IN=0x2A.
- sub with REGOUT1=0x10, REGOUT2=0x03 -> ALU_DATA2=0xFD, ALU_SELECT=001, IN=0x0D.
- beq, offset 0xFE:
  - REGOUT1=REGOUT2=0x55 with ALU_ZERO=1 -> BRANCH_TAKEN=1, BRANCH_OFFSET=0xFE, WRITEENABLE=0.
  - Repeat with ALU_ZERO=0 -> no strobe. bne shows the inverse.
- mult with MULT_CYCLES=3, REGOUT1=0x05, REGOUT2=0x04 -> ALU_SELECT=111 held 3 cycles, IN=0x14 at cycle 5. INSTR_VALID held high throughout is accepted only on return to IDLE.
- Opcode 0xF0:
  - With ILLEGAL_TRAP_EN: ILLEGAL=1, INSTR_READY stays 0.
  - Without it: retires in 2 cycles with no strobes, next instruction accepted.
